// File: rtl/board_pkg.sv
// Shared board geometry and cell encodings for the mclk-domain board logic.
package board_pkg;

    localparam int BOARD_W   = 32;
    localparam int BOARD_H   = 16;
    localparam int CELL_BITS = 4;
    localparam int X_BITS    = 5;
    localparam int Y_BITS    = 4;

    typedef enum logic [CELL_BITS-1:0] {
        CELL_EMPTY = 4'h0,
        CELL_SNAKE = 4'h1,
        CELL_FOOD  = 4'h2,
        CELL_WALL  = 4'h3
    } cell_t;

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } arb_state_t;

endpackage

// File: rtl/board_clear_seq.sv
// Board fill sequencer: walks every cell x-fastest and offers one write per cycle.
module board_clear_seq
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CELL_BITS-1:0] value,
    output logic                 issue,
    output logic [X_BITS-1:0]    x,
    output logic [Y_BITS-1:0]    y,
    output logic [CELL_BITS-1:0] data,
    output logic                 busy,
    output logic                 done
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(BOARD_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(BOARD_H - 1);

    logic                 run;
    logic                 last;
    logic [X_BITS-1:0]    cx;
    logic [X_BITS-1:0]    nx;
    logic [Y_BITS-1:0]    cy;
    logic [Y_BITS-1:0]    ny;
    logic [CELL_BITS-1:0] fill;

    // The first write goes out in the start cycle so the RAM port
    // shows (0,0) in the very first CLEAR cycle.
    always_comb begin
        issue = start || run;
        x     = start ? '0 : cx;
        y     = start ? '0 : cy;
        data  = start ? value : fill;
        last  = issue && (x == X_LAST) && (y == Y_LAST);
        nx    = x + 1'b1;
        ny    = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run  <= 1'b0;
            cx   <= '0;
            cy   <= '0;
            fill <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= issue;
            done <= last;
            if (start) begin
                fill <= value;
            end
            if (issue) begin
                cx  <= nx;
                cy  <= ny;
                run <= !last;
            end
        end
    end

endmodule

// File: rtl/board_port_arbiter.sv
// Port-B owner of the board RAM: game/EPP round-robin plus the clear sequencer.
module board_port_arbiter
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 g_req,
    input  logic                 g_we,
    input  logic [X_BITS-1:0]    g_x,
    input  logic [Y_BITS-1:0]    g_y,
    input  logic [CELL_BITS-1:0] g_din,
    output logic                 g_gnt,
    output logic                 g_rvalid,
    output logic [CELL_BITS-1:0] g_rdata,
    input  logic                 e_req,
    input  logic [X_BITS-1:0]    e_x,
    input  logic [Y_BITS-1:0]    e_y,
    input  logic [CELL_BITS-1:0] e_din,
    output logic                 e_gnt,
    input  logic                 clr_start,
    input  logic [CELL_BITS-1:0] clr_value,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic [X_BITS-1:0]    ram_x,
    output logic [Y_BITS-1:0]    ram_y,
    output logic [CELL_BITS-1:0] ram_in,
    output logic                 ram_rd,
    output logic                 ram_wr,
    input  logic [CELL_BITS-1:0] ram_out
);

    arb_state_t           state;
    logic                 game_first;
    logic                 rd_pend;
    logic                 arb_open;
    logic                 seq_start;
    logic                 seq_issue;
    logic [X_BITS-1:0]    seq_x;
    logic [Y_BITS-1:0]    seq_y;
    logic [CELL_BITS-1:0] seq_data;

    always_comb begin
        arb_open  = rst && (state == ST_ARB) && !clr_start;
        g_gnt     = arb_open && g_req && (!e_req || game_first);
        e_gnt     = arb_open && e_req && (!g_req || !game_first);
        seq_start = rst && (state == ST_ARB) && clr_start;
    end

    assign g_rdata = g_rvalid ? ram_out : '0;

    board_clear_seq u_clr (
        .clk   (clk),
        .rst   (rst),
        .start (seq_start),
        .value (clr_value),
        .issue (seq_issue),
        .x     (seq_x),
        .y     (seq_y),
        .data  (seq_data),
        .busy  (clr_busy),
        .done  (clr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_ARB;
            game_first <= 1'b1;
            rd_pend    <= 1'b0;
            g_rvalid   <= 1'b0;
            ram_x      <= '0;
            ram_y      <= '0;
            ram_in     <= '0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
        end else begin
            g_rvalid <= rd_pend;
            rd_pend  <= g_gnt && !g_we;
            ram_rd   <= 1'b0;
            ram_wr   <= 1'b0;
            unique case (1'b1)
                seq_issue: begin
                    ram_x  <= seq_x;
                    ram_y  <= seq_y;
                    ram_in <= seq_data;
                    ram_wr <= 1'b1;
                end
                g_gnt: begin
                    ram_x      <= g_x;
                    ram_y      <= g_y;
                    ram_in     <= g_din;
                    ram_rd     <= !g_we;
                    ram_wr     <= g_we;
                    game_first <= 1'b0;
                end
                e_gnt: begin
                    ram_x      <= e_x;
                    ram_y      <= e_y;
                    ram_in     <= e_din;
                    ram_wr     <= 1'b1;
                    game_first <= 1'b1;
                end
                default: ;
            endcase
            unique case (state)
                ST_ARB:   if (seq_start) state <= ST_CLEAR;
                ST_CLEAR: if (clr_done) state <= ST_ARB;
                default:  state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Randomized bench for board_port_arbiter against a cycle-level reference model.
module tb_board_port_arbiter;
    import board_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       g_req, g_we, g_gnt, g_rvalid;
    logic [4:0] g_x;
    logic [3:0] g_y, g_din, g_rdata;
    logic       e_req, e_gnt;
    logic [4:0] e_x;
    logic [3:0] e_y, e_din;
    logic       clr_start, clr_busy, clr_done;
    logic [3:0] clr_value;
    logic [4:0] ram_x;
    logic [3:0] ram_y, ram_in, ram_out;
    logic       ram_rd, ram_wr;

    always #5 clk = ~clk;

    board_port_arbiter dut (
        .clk(clk), .rst(rst),
        .g_req(g_req), .g_we(g_we), .g_x(g_x), .g_y(g_y), .g_din(g_din),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .e_req(e_req), .e_x(e_x), .e_y(e_y), .e_din(e_din), .e_gnt(e_gnt),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_x(ram_x), .ram_y(ram_y), .ram_in(ram_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_out(ram_out)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM environment and reference memory
    logic [3:0] ram_mem [512];
    logic [3:0] mem_ref [512];

    // Reference model: expected port state for the current cycle
    bit         m_clr;
    int         m_pos;
    logic [3:0] m_val;
    bit         m_last_g;
    logic       exp_rd, exp_wr, exp_busy, exp_done, exp_rv;
    logic [4:0] exp_x;
    logic [3:0] exp_y, exp_in, exp_rdata;

    logic       dut_g, dut_e, dut_rv, dut_rd, dut_busy;
    logic [4:0] dut_x;
    logic [3:0] dut_y, dut_rdata;
    int         wr_cnt, done_cnt;

    task automatic step();
        bit         mg, me, n_rv;
        logic [3:0] n_rdata;
        logic       p_rd, p_wr;
        int         pa, a;
        logic [3:0] pd;
        @(negedge clk);
        chk("ram_rd", 32'(ram_rd), 32'(exp_rd));
        chk("ram_wr", 32'(ram_wr), 32'(exp_wr));
        chk("ram_x", 32'(ram_x), 32'(exp_x));
        chk("ram_y", 32'(ram_y), 32'(exp_y));
        chk("ram_in", 32'(ram_in), 32'(exp_in));
        chk("clr_busy", 32'(clr_busy), 32'(exp_busy));
        chk("clr_done", 32'(clr_done), 32'(exp_done));
        chk("g_rvalid", 32'(g_rvalid), 32'(exp_rv));
        if (exp_rv) chk("g_rdata", 32'(g_rdata), 32'(exp_rdata));
        if (!rst || m_clr || clr_start) begin
            mg = 0;
            me = 0;
        end else if (g_req && e_req) begin
            mg = !m_last_g;
            me = m_last_g;
        end else begin
            mg = g_req;
            me = e_req;
        end
        chk("g_gnt", 32'(g_gnt), 32'(mg));
        chk("e_gnt", 32'(e_gnt), 32'(me));
        chk("one_gnt", 32'(g_gnt & e_gnt), 0);
        dut_g = g_gnt; dut_e = e_gnt; dut_rv = g_rvalid; dut_rdata = g_rdata;
        dut_rd = ram_rd; dut_x = ram_x; dut_y = ram_y; dut_busy = clr_busy;
        if (ram_wr && clr_busy) wr_cnt++;
        if (clr_done) done_cnt++;
        p_rd = ram_rd; p_wr = ram_wr; pa = int'({ram_y, ram_x}); pd = ram_in;

        a = int'({exp_y, exp_x});
        n_rv = rst && exp_rd;
        n_rdata = mem_ref[a];
        if (exp_wr) mem_ref[a] = exp_in;
        if (!rst) begin
            exp_rd = 0; exp_wr = 0; exp_x = 0; exp_y = 0; exp_in = 0;
            exp_busy = 0; exp_done = 0; m_clr = 0; m_last_g = 0;
        end else if (m_clr) begin
            exp_rd = 0;
            if (m_pos == BOARD_W * BOARD_H - 1) begin
                m_clr = 0; exp_wr = 0; exp_busy = 0; exp_done = 0;
            end else begin
                m_pos++;
                exp_wr = 1; exp_x = 5'(m_pos % BOARD_W); exp_y = 4'(m_pos / BOARD_W);
                exp_in = m_val; exp_busy = 1;
                exp_done = (m_pos == BOARD_W * BOARD_H - 1);
            end
        end else if (clr_start) begin
            m_clr = 1; m_pos = 0; m_val = clr_value;
            exp_rd = 0; exp_wr = 1; exp_x = 0; exp_y = 0; exp_in = clr_value;
            exp_busy = 1; exp_done = 0;
        end else begin
            exp_busy = 0; exp_done = 0;
            if (mg) begin
                exp_rd = !g_we; exp_wr = g_we; exp_x = g_x; exp_y = g_y;
                exp_in = g_din; m_last_g = 1;
            end else if (me) begin
                exp_rd = 0; exp_wr = 1; exp_x = e_x; exp_y = e_y;
                exp_in = e_din; m_last_g = 0;
            end else begin
                exp_rd = 0; exp_wr = 0;
            end
        end
        exp_rv = n_rv;
        exp_rdata = n_rdata;

        @(posedge clk);
        if (p_wr) ram_mem[pa] = pd;
        if (p_rd) ram_out = ram_mem[pa];
        #1;
    endtask

    task automatic game_op(input logic we, input logic [4:0] x,
                           input logic [3:0] y, input logic [3:0] d);
        int n;
        n = 0;
        g_req = 1; g_we = we; g_x = x; g_y = y; g_din = d;
        do begin
            step();
            n++;
        end while (!dut_g && n < 16);
        chk("gop_gnt", 32'(dut_g), 1);
        g_req = 0;
    endtask

    logic [3:0] gbits, ebits;
    logic [4:0] rvh;
    logic [3:0] rdh [5];
    int         ecnt, nz;

    initial begin
        rst = 0; g_req = 0; g_we = 0; g_x = 0; g_y = 0; g_din = 0;
        e_req = 0; e_x = 0; e_y = 0; e_din = 0;
        clr_start = 0; clr_value = 0; ram_out = 0;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 4'($urandom);
            mem_ref[i] = ram_mem[i];
        end
        exp_rd = 0; exp_wr = 0; exp_x = 0; exp_y = 0; exp_in = 0;
        exp_busy = 0; exp_done = 0; exp_rv = 0; exp_rdata = 0;
        m_clr = 0; m_pos = 0; m_val = 0; m_last_g = 0;
        wr_cnt = 0; done_cnt = 0; dut_g = 0; dut_e = 0;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("rst_rdata", 32'(g_rdata), 0);
        rst = 1;

        // Contention from reset: G, E, G, E
        g_req = 1; e_req = 1; g_we = 1; g_x = 5'd9; g_y = 4'd4; g_din = 4'h2;
        e_x = 5'd17; e_y = 4'd8; e_din = 4'h3;
        for (int k = 0; k < 4; k++) begin
            step();
            gbits[3-k] = dut_g;
            ebits[3-k] = dut_e;
        end
        g_req = 0; e_req = 0;
        chk("cont_g", 32'(gbits), 32'(4'b1010));
        chk("cont_e", 32'(ebits), 32'(4'b0101));

        // Single game read of a preloaded cell
        game_op(1, 5'd3, 4'd2, 4'h5);
        game_op(0, 5'd3, 4'd2, 4'h0);
        step();
        chk("rd_ram_rd", 32'(dut_rd), 1);
        chk("rd_ram_x", 32'(dut_x), 3);
        chk("rd_ram_y", 32'(dut_y), 2);
        step();
        chk("rd_rvalid", 32'(dut_rv), 1);
        chk("rd_rdata", 32'(dut_rdata), 5);

        // Back-to-back reads
        game_op(1, 5'd0, 4'd0, 4'hA);
        game_op(1, 5'd1, 4'd0, 4'hB);
        game_op(1, 5'd2, 4'd0, 4'hC);
        g_we = 0; g_y = 0;
        for (int k = 0; k < 5; k++) begin
            g_req = (k < 3);
            g_x = (k < 3) ? 5'(k) : 5'd0;
            step();
            rvh[k] = dut_rv;
            rdh[k] = dut_rdata;
        end
        g_req = 0;
        chk("pipe_rv", 32'(rvh), 32'(5'b11100));
        chk("pipe_d0", 32'(rdh[2]), 32'hA);
        chk("pipe_d1", 32'(rdh[3]), 32'hB);
        chk("pipe_d2", 32'(rdh[4]), 32'hC);

        // Prefill with F, then clear to 0 with EPP waiting
        g_req = 1; g_we = 1; g_din = 4'hF;
        for (int i = 0; i < 512; i++) begin
            g_x = 5'(i % 32);
            g_y = 4'(i / 32);
            step();
        end
        g_we = 0; g_x = 5'd5; g_y = 4'd5;
        step();
        g_req = 0;
        clr_start = 1; clr_value = 4'h0;
        e_req = 1; e_x = 5'd7; e_y = 4'd3; e_din = 4'h0;
        wr_cnt = 0; done_cnt = 0; ecnt = 0;
        step();
        for (int k = 0; k < 512; k++) begin
            clr_start = (k == 100);
            clr_value = (k == 100) ? 4'h7 : 4'h0;
            step();
            if (dut_e) ecnt++;
            if (k == 0) begin
                chk("clr_pre_rv", 32'(dut_rv), 1);
                chk("clr_pre_rd", 32'(dut_rdata), 32'hF);
            end
        end
        clr_start = 0;
        step();
        chk("clr_e_after", 32'(dut_e), 1);
        e_req = 0;
        chk("clr_wr_cnt", 32'(wr_cnt), 512);
        chk("clr_done_cnt", 32'(done_cnt), 1);
        chk("clr_e_during", 32'(ecnt), 0);
        nz = 0;
        for (int i = 0; i < 512; i++) if (ram_mem[i] != 4'h0) nz++;
        chk("vga_zero", 32'(nz), 0);

        // Reset in the middle of a clear
        clr_start = 1; clr_value = 4'h9;
        step();
        clr_start = 0; done_cnt = 0;
        repeat (200) step();
        rst = 0;
        g_req = 1; g_we = 1; g_x = 5'd12; g_y = 4'd6; g_din = 4'h4;
        step();
        rst = 1;
        step();
        chk("rst_clr_busy", 32'(dut_busy), 0);
        chk("rst_gnt", 32'(dut_g), 1);
        g_req = 0;
        repeat (600) step();
        chk("rst_no_done", 32'(done_cnt), 0);

        // Random traffic with requesters holding until granted
        for (int c = 0; c < 3000; c++) begin
            if (!g_req || dut_g) begin
                g_req = ($urandom_range(0, 2) != 0);
                g_we = 1'($urandom_range(0, 1));
                g_x = 5'($urandom); g_y = 4'($urandom); g_din = 4'($urandom);
            end
            if (!e_req || dut_e) begin
                e_req = ($urandom_range(0, 1) != 0);
                e_x = 5'($urandom); e_y = 4'($urandom); e_din = 4'($urandom);
            end
            clr_start = ($urandom_range(0, 499) == 0);
            clr_value = 4'($urandom);
            rst = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
